// File: rtl/lsu_sq.sv
// Store queue: holds speculative stores from LSU_ID, writes one retiring
// store at a time to the data cache and broadcasts it to the load queue.
module lsu_sq #(
  parameter int SQ_DEPTH = 8,
  parameter int TAG_W    = 6,
  parameter int ADDR_W   = 32,
  parameter int FUNC_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  output logic              o_full,
  input  logic              i_alloc_en,
  input  logic [TAG_W-1:0]  i_alloc_tag,
  input  logic [ADDR_W-1:0] i_alloc_addr,
  input  logic [31:0]       i_alloc_data,
  input  logic [FUNC_W-1:0] i_alloc_lsu_func,
  input  logic              i_rob_retire_en,
  input  logic [TAG_W-1:0]  i_rob_retire_tag,
  output logic              o_rob_retire_stall,
  output logic              o_dc_en,
  output logic [ADDR_W-1:0] o_dc_addr,
  output logic [31:0]       o_dc_data,
  output logic [FUNC_W-1:0] o_dc_lsu_func,
  input  logic              i_dc_ready,
  output logic              o_sq_retire_en,
  output logic [ADDR_W-1:0] o_sq_retire_addr,
  output logic [FUNC_W-1:0] o_sq_retire_lsu_func
);

  localparam int IDX_W = $clog2(SQ_DEPTH);

  typedef enum logic {
    IDLE,
    DC_REQ
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ret_idx;
  logic [SQ_DEPTH-1:0] slot_valid;
  logic [SQ_DEPTH-1:0] valid_next;

  logic [ADDR_W-1:0]   slot_addr [SQ_DEPTH];
  logic [31:0]         slot_data [SQ_DEPTH];
  logic [FUNC_W-1:0]   slot_func [SQ_DEPTH];
  logic [TAG_W-1:0]    slot_tag  [SQ_DEPTH];

  logic [IDX_W-1:0]    alloc_idx;
  logic [IDX_W-1:0]    match_idx;
  logic                alloc_found;
  logic                match_found;
  logic                alloc_go;
  logic                retire_go;
  logic                dc_done;

  // Lowest-index free slot and lowest-index valid slot matching the retire tag
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      if (!slot_valid[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      if (slot_valid[i] && (slot_tag[i] == i_rob_retire_tag) && !match_found) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end
  end

  assign o_full    = &slot_valid;
  assign alloc_go  = i_alloc_en && !o_full && !i_flush;
  assign retire_go = (state == IDLE) && i_rob_retire_en && match_found;
  assign dc_done   = (state == DC_REQ) && i_dc_ready;

  // Next valid vector. Flush wipes everything except the store that is
  // already committed to retire: the one in flight to the cache (unless it
  // finishes this cycle) or the one being accepted right now.
  always_comb begin
    valid_next = slot_valid;
    if (dc_done) valid_next[ret_idx] = 1'b0;
    if (alloc_go) valid_next[alloc_idx] = 1'b1;
    if (i_flush) begin
      valid_next = '0;
      if ((state == DC_REQ) && !i_dc_ready) valid_next[ret_idx] = 1'b1;
      if (retire_go) valid_next[match_idx] = 1'b1;
    end
  end

  // Slot valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_valid <= '0;
    else     slot_valid <= valid_next;
  end

  // Slot payload capture on allocation; payload needs no reset
  always_ff @(posedge clk) begin
    if (alloc_go) begin
      slot_addr[alloc_idx] <= i_alloc_addr;
      slot_data[alloc_idx] <= i_alloc_data;
      slot_func[alloc_idx] <= i_alloc_lsu_func;
      slot_tag[alloc_idx]  <= i_alloc_tag;
    end
  end

  // Retire FSM: accept a matching retire in IDLE, hold the cache write in DC_REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ret_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (retire_go) begin
            ret_idx <= match_idx;
            state   <= DC_REQ;
          end
        end
        DC_REQ: begin
          if (i_dc_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_rob_retire_stall   = (state == DC_REQ);
  assign o_dc_en              = (state == DC_REQ);
  assign o_dc_addr            = o_dc_en ? slot_addr[ret_idx] : '0;
  assign o_dc_data            = o_dc_en ? slot_data[ret_idx] : '0;
  assign o_dc_lsu_func        = o_dc_en ? slot_func[ret_idx] : '0;
  assign o_sq_retire_en       = dc_done;
  assign o_sq_retire_addr     = dc_done ? slot_addr[ret_idx] : '0;
  assign o_sq_retire_lsu_func = dc_done ? slot_func[ret_idx] : '0;

endmodule

// File: tb/tb_lsu_sq.sv
// Directed bench for lsu_sq: a cycle-by-cycle vector table plus hand-built
// sequences for flush and asynchronous reset corner cases.
module tb_lsu_sq;

  localparam logic [3:0] F_LW = 4'd2;
  localparam logic [3:0] F_SB = 4'd5;
  localparam logic [3:0] F_SH = 4'd6;
  localparam logic [3:0] F_SW = 4'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        o_full;
  logic        i_alloc_en = 1'b0;
  logic [5:0]  i_alloc_tag = '0;
  logic [31:0] i_alloc_addr = '0;
  logic [31:0] i_alloc_data = '0;
  logic [3:0]  i_alloc_lsu_func = '0;
  logic        i_rob_retire_en = 1'b0;
  logic [5:0]  i_rob_retire_tag = '0;
  logic        o_rob_retire_stall;
  logic        o_dc_en;
  logic [31:0] o_dc_addr;
  logic [31:0] o_dc_data;
  logic [3:0]  o_dc_lsu_func;
  logic        i_dc_ready = 1'b0;
  logic        o_sq_retire_en;
  logic [31:0] o_sq_retire_addr;
  logic [3:0]  o_sq_retire_lsu_func;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lsu_sq #(.SQ_DEPTH(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_flush             (i_flush),
    .o_full              (o_full),
    .i_alloc_en          (i_alloc_en),
    .i_alloc_tag         (i_alloc_tag),
    .i_alloc_addr        (i_alloc_addr),
    .i_alloc_data        (i_alloc_data),
    .i_alloc_lsu_func    (i_alloc_lsu_func),
    .i_rob_retire_en     (i_rob_retire_en),
    .i_rob_retire_tag    (i_rob_retire_tag),
    .o_rob_retire_stall  (o_rob_retire_stall),
    .o_dc_en             (o_dc_en),
    .o_dc_addr           (o_dc_addr),
    .o_dc_data           (o_dc_data),
    .o_dc_lsu_func       (o_dc_lsu_func),
    .i_dc_ready          (i_dc_ready),
    .o_sq_retire_en      (o_sq_retire_en),
    .o_sq_retire_addr    (o_sq_retire_addr),
    .o_sq_retire_lsu_func(o_sq_retire_lsu_func)
  );

  typedef struct {
    logic        alloc_en;
    logic [5:0]  alloc_tag;
    logic [31:0] alloc_addr;
    logic [31:0] alloc_data;
    logic [3:0]  alloc_func;
    logic        ret_en;
    logic [5:0]  ret_tag;
    logic        dc_ready;
    logic        flush;
    logic        e_full;
    logic        e_stall;
    logic        e_dc_en;
    logic [31:0] e_dc_addr;
    logic [31:0] e_dc_data;
    logic [3:0]  e_dc_func;
    logic        e_sq_en;
    logic [31:0] e_sq_addr;
    logic [3:0]  e_sq_func;
  } vec_t;

  function automatic vec_t nop(input logic full);
    vec_t v;
    v = '{default: '0};
    v.e_full = full;
    return v;
  endfunction

  function automatic vec_t al(input vec_t vi, input logic [5:0] t, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] f);
    vec_t v = vi;
    v.alloc_en = 1'b1; v.alloc_tag = t; v.alloc_addr = a; v.alloc_data = d; v.alloc_func = f;
    return v;
  endfunction

  function automatic vec_t rt(input vec_t vi, input logic [5:0] t);
    vec_t v = vi;
    v.ret_en = 1'b1; v.ret_tag = t;
    return v;
  endfunction

  function automatic vec_t fl(input vec_t vi);
    vec_t v = vi;
    v.flush = 1'b1;
    return v;
  endfunction

  // Expect a cache write in progress; with ready=1 it also completes this cycle
  function automatic vec_t dc(input vec_t vi, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] f, input logic ready);
    vec_t v = vi;
    v.dc_ready = ready; v.e_stall = 1'b1; v.e_dc_en = 1'b1;
    v.e_dc_addr = a; v.e_dc_data = d; v.e_dc_func = f;
    if (ready) begin
      v.e_sq_en = 1'b1; v.e_sq_addr = a; v.e_sq_func = f;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic check_outputs(input string nm, input int idx, input vec_t v);
    chk({nm, ".full"},    idx, 32'(o_full),               32'(v.e_full));
    chk({nm, ".stall"},   idx, 32'(o_rob_retire_stall),   32'(v.e_stall));
    chk({nm, ".dc_en"},   idx, 32'(o_dc_en),              32'(v.e_dc_en));
    chk({nm, ".dc_addr"}, idx, o_dc_addr,                 v.e_dc_addr);
    chk({nm, ".dc_data"}, idx, o_dc_data,                 v.e_dc_data);
    chk({nm, ".dc_func"}, idx, 32'(o_dc_lsu_func),        32'(v.e_dc_func));
    chk({nm, ".sq_en"},   idx, 32'(o_sq_retire_en),       32'(v.e_sq_en));
    chk({nm, ".sq_addr"}, idx, o_sq_retire_addr,          v.e_sq_addr);
    chk({nm, ".sq_func"}, idx, 32'(o_sq_retire_lsu_func), 32'(v.e_sq_func));
  endtask

  // Called just after a rising edge: drive, check on the falling edge, advance
  task automatic step(input string nm, input int idx, input vec_t v);
    i_alloc_en       = v.alloc_en;
    i_alloc_tag      = v.alloc_tag;
    i_alloc_addr     = v.alloc_addr;
    i_alloc_data     = v.alloc_data;
    i_alloc_lsu_func = v.alloc_func;
    i_rob_retire_en  = v.ret_en;
    i_rob_retire_tag = v.ret_tag;
    i_dc_ready       = v.dc_ready;
    i_flush          = v.flush;
    @(negedge clk);
    check_outputs(nm, idx, v);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[20];
  vec_t zero_v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main table: fill, overflow, retire tag 3 with stalled cache, reuse of freed slot
    for (int k = 1; k <= 8; k++)
      tbl[k-1] = al(nop(1'b0), 6'(k), 32'((k-1)*32'h80),
                    (k == 3) ? 32'hDEADBEEF : 32'h1000 + 32'(k), F_SW);
    tbl[8]  = al(nop(1'b1), 6'd9, 32'h900, 32'h99, F_SB);
    tbl[9]  = rt(nop(1'b1), 6'd3);
    for (int k = 10; k <= 12; k++)
      tbl[k] = dc(rt(nop(1'b1), 6'd3), 32'h100, 32'hDEADBEEF, F_SW, 1'b0);
    tbl[13] = dc(al(nop(1'b1), 6'd9, 32'h900, 32'h99, F_SB), 32'h100, 32'hDEADBEEF, F_SW, 1'b1);
    tbl[14] = al(nop(1'b0), 6'd9, 32'h900, 32'h99, F_SB);
    tbl[15] = rt(nop(1'b1), 6'd9);
    tbl[16] = dc(nop(1'b1), 32'h900, 32'h99, F_SB, 1'b1);
    tbl[17] = rt(nop(1'b0), 6'h3F);
    tbl[18] = rt(nop(1'b0), 6'd3);
    tbl[19] = nop(1'b0);

    // Reset state, with inputs active while rst is high
    zero_v = rt(al(nop(1'b0), 6'd1, 32'h10, 32'h11, F_SW), 6'd1);
    zero_v.dc_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    step("rst", 0, zero_v);
    step("rst", 1, zero_v);
    rst = 1'b0;

    foreach (tbl[i]) step("tbl", i, tbl[i]);

    // Asynchronous reset mid-DC_REQ: valid now tags 1,2,4..8
    step("arst", 0, rt(nop(1'b0), 6'd4));
    step("arst", 1, dc(nop(1'b0), 32'h180, 32'h1004, F_SW, 1'b0));
    i_dc_ready = 1'b1;
    #1;
    chk("arst.pre_dc_en", 0, 32'(o_dc_en), 32'd1);
    chk("arst.pre_sq_en", 0, 32'(o_sq_retire_en), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs("arst.now", 0, nop(1'b0));
    @(posedge clk); #1;
    check_outputs("arst.held", 0, nop(1'b0));
    rst = 1'b0;
    i_dc_ready = 1'b0;
    step("arst", 2, nop(1'b0));

    // Flush in DC_REQ with 5 valid slots; retire accepted alongside an allocation
    for (int k = 1; k <= 4; k++)
      step("fdc", k, al(nop(1'b0), 6'(k), 32'(k*16), 32'hB0 + 32'(k), F_LW));
    step("fdc", 5, rt(al(nop(1'b0), 6'd5, 32'h50, 32'hB5, F_LW), 6'd4));
    step("fdc", 6, fl(dc(nop(1'b0), 32'h40, 32'hB4, F_LW, 1'b0)));
    step("fdc", 7, dc(nop(1'b0), 32'h40, 32'hB4, F_LW, 1'b0));
    step("fdc", 8, dc(nop(1'b0), 32'h40, 32'hB4, F_LW, 1'b1));
    step("fdc", 9, rt(nop(1'b0), 6'd1));
    step("fdc", 10, rt(nop(1'b0), 6'd5));
    step("fdc", 11, nop(1'b0));

    // Refill all 8 slots after the flush, then flush during a retire accept
    for (int k = 1; k <= 8; k++)
      step("fill", k, al(nop(1'b0), 6'h30 + 6'(k), 32'h2000 + 32'(k), 32'h5000 + 32'(k), F_SH));
    step("facc", 1, al(fl(rt(nop(1'b1), 6'h33)), 6'h40, 32'h4000, 32'h40, F_SB));
    step("facc", 2, al(dc(nop(1'b0), 32'h2003, 32'h5003, F_SH, 1'b1), 6'h41, 32'h4100, 32'h41, F_SB));
    step("facc", 3, al(fl(rt(nop(1'b0), 6'h41)), 6'h42, 32'h4200, 32'h42, F_SB));
    step("facc", 4, dc(nop(1'b0), 32'h4100, 32'h41, F_SB, 1'b1));
    step("facc", 5, rt(nop(1'b0), 6'h42));
    step("facc", 6, rt(al(nop(1'b0), 6'h11, 32'h5100, 32'h51, F_LW), 6'h31));
    step("facc", 7, rt(al(nop(1'b0), 6'h12, 32'h5200, 32'h52, F_LW), 6'h11));
    step("facc", 8, dc(nop(1'b0), 32'h5100, 32'h51, F_LW, 1'b1));
    step("facc", 9, rt(nop(1'b0), 6'h12));
    step("facc", 10, dc(nop(1'b0), 32'h5200, 32'h52, F_LW, 1'b1));
    step("facc", 11, nop(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
